obi_bridge_arbiter: RTL
=======================

Name: obi_bridge_arbiter

Overview:
- Shares the single OBI slave bridge port of gr_heep_top (req/we/be/addr/wdata -> gnt/rvalid/rdata) between NumReq external masters, e.g. the CW305 host register interface and a testbench program loader.
- Arbitrates requests, holding the selection stable until the slave grants.
- Tracks outstanding transactions in an ID FIFO so that in-order responses are routed back to the originating requester.

Parameters:
- NumReq, 2, number of upstream requesters (>=2).
- MaxOutstanding, 2, maximum granted-but-unanswered transactions (>=1, power of two).
- IdxW, $clog2(NumReq), derived; requester index width.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- req_i  input  NumReq  per-requester request.
- we_i  input  NumReq  per-requester write enable.
- be_i  input  NumReq x 4  per-requester byte enables.
- addr_i  input  NumReq x 32  per-requester address.
- wdata_i  input  NumReq x 32  per-requester write data.
- gnt_o  output  NumReq  per-requester grant.
- rvalid_o  output  NumReq  per-requester response valid.
- rdata_o  output  NumReq x 32  per-requester read data; bus_rdata_i is broadcast to all requesters, qualified by rvalid_o.
- bus_req_o  output  1  request to the bridge.
- bus_we_o  output  1  write enable to the bridge.
- bus_be_o  output  4  byte enables to the bridge.
- bus_addr_o  output  32  address to the bridge.
- bus_wdata_o  output  32  write data to the bridge.
- bus_gnt_i  input  1  grant from the bridge.
- bus_rvalid_i  input  1  response valid from the bridge.
- bus_rdata_i  input  32  read data from the bridge.

Behaviour:
- One clock (clk_i); asynchronous active-low reset (rst_ni).
- Reset values: rr pointer=0, state=IDLE, FIFO empty, outstanding count=0. All outputs 0 while in reset.
- State machine IDLE:
  - If any req_i is set and the FIFO is not full, select the winner combinationally.
  - Drive bus_* from the winner; bus_req_o=1.
  - If bus_gnt_i=1 in the same cycle: gnt_o[winner]=1, push the winner index, stay in IDLE.
  - Otherwise latch the winner into sel_q and go to HOLD.
- State machine HOLD:
  - Drive bus_* from sel_q only; other requests are ignored. This satisfies OBI address-phase stability.
  - On bus_gnt_i: gnt_o[sel_q]=1, push, return to IDLE.
  - If req_i[sel_q] drops before grant (protocol violation by the requester): return to IDLE without a grant.
- Round-robin:
  - Winner is the first asserted req_i at or after rr pointer, wrapping modulo NumReq.
  - On each accepted handshake the pointer becomes winner+1, wrapping to 0 at NumReq.
- Back-pressure:
  - FIFO full (count==MaxOutstanding) in IDLE: bus_req_o=0 and no gnt_o.
  - A pop in the same cycle does NOT free a slot for a new request; the full flag is registered.
- Responses:
  - On bus_rvalid_i, assert rvalid_o[fifo head] and pop. Zero-cycle latency from bus_rvalid_i to rvalid_o.
  - bus_rvalid_i while the FIFO is empty is dropped; a sticky internal error flag is set.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Grant and rvalid in the same cycle for the same requester is legal and passed through.
- gnt_o is purely combinational from bus_gnt_i and the selection; there is no added grant latency.
- Reset mid-transaction: all outstanding IDs are discarded. Later bus_rvalid_i then hits an empty FIFO; the slave is reset together with this block.

Optional Feature:
- OBI_ARB_FIXED_PRIO_EN defined: fixed priority. The lowest index wins, the rr pointer is removed, and HOLD behaviour is unchanged.
- Undefined: round-robin as described in Behaviour.

Decomposition:
- Package obi_bridge_arb_pkg:
  - obi_req_t struct {req, we, be[3:0], addr[31:0], wdata[31:0]}.
  - obi_rsp_t struct {gnt, rvalid, rdata[31:0]}.
  - state enum {IDLE, HOLD}.
  - Localparam ObiDataW=32.
- Sub-module obi_arb_id_fifo: depth MaxOutstanding, width IdxW. Ports push/pop/data/full/empty, registered full flag.

Test Plan:
- Single requester 0, read addr 0x2000_0000, bus_gnt_i same cycle, rvalid 2 cycles later with rdata 0xDEAD_BEEF -> gnt_o=2'b01 for 1 cycle; rvalid_o=2'b01 with rdata_o[0]=0xDEAD_BEEF.
- Both requesting continuously, slave always grants -> gnt_o alternates 01,10,01,10; responses are routed in matching order.
- Req 1 raises while requester 0 is in HOLD (grant delayed 3 cycles) -> bus_addr_o stays at requester 0's addr all 3 cycles; requester 1 is granted next.
- MaxOutstanding=2: two grants with no rvalid -> bus_req_o=0 on the third request until a response pops, then a request reissues one cycle later.
- rst_ni pulsed low with 2 outstanding -> FIFO empty, state IDLE, all outputs 0; a spurious bus_rvalid_i produces no rvalid_o.
- With OBI_ARB_FIXED_PRIO_EN, both requesting -> gnt_o[0] on every cycle; requester 1 is starved.

Source files
------------

// File: rtl/obi_bridge_arb_pkg.sv
// -----------------------------------------------------------------------------
// obi_bridge_arb_pkg
// Shared types and constants for the OBI bridge arbiter slice.
//   obi_req_t  : request-channel bundle as driven towards the bridge.
//   obi_rsp_t  : response-channel bundle as returned by the bridge.
//   IDLE/HOLD  : arbiter FSM state encodings.
//   arb_dbg_t  : observable arbiter status (FSM state, sticky error).
// -----------------------------------------------------------------------------
package obi_bridge_arb_pkg;

    localparam int unsigned ObiDataW = 32;
    localparam int unsigned ObiBeW   = ObiDataW / 8;

    typedef struct packed {
        logic                req;
        logic                we;
        logic [ObiBeW-1:0]   be;
        logic [ObiDataW-1:0] addr;
        logic [ObiDataW-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic                gnt;
        logic                rvalid;
        logic [ObiDataW-1:0] rdata;
    } obi_rsp_t;

    // Arbiter FSM states
    localparam logic [0:0] IDLE = 1'b0;  // free to pick a new winner
    localparam logic [0:0] HOLD = 1'b1;  // address phase locked to sel_q

    typedef struct packed {
        logic [0:0] state;
        logic       err;
    } arb_dbg_t;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// -----------------------------------------------------------------------------
// obi_arb_id_fifo
// Small FIFO holding the requester index of every granted-but-unanswered
// transaction, so in-order responses can be routed back.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : enqueue a requester index (ignored when full)
//   pop_i/data_o  : dequeue the head (ignored when empty); data_o is the head
//   full_o        : registered; reflects the occupancy at the start of the
//                   cycle, so a same-cycle pop never frees a slot early
//   empty_o       : no entries
// -----------------------------------------------------------------------------
module obi_arb_id_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             full_q;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
            full_q  <= (count_d == CntW'(Depth));
        end
    end

    // Storage needs no reset: entries are only read while count_q says valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/obi_bridge_arbiter.sv
// -----------------------------------------------------------------------------
// obi_bridge_arbiter
// Shares one OBI slave bridge port between NumReq upstream masters.
// Arbitrates requests, holds the selection stable until the bridge grants, and
// routes in-order responses back through an ID FIFO.
//
// Ports:
//   clk_i, rst_ni                    : clock, asynchronous active-low reset
//   req_i/we_i/be_i/addr_i/wdata_i   : per-requester request (flattened, index
//                                      r occupies slice r of each vector)
//   gnt_o/rvalid_o/rdata_o           : per-requester response; rdata_o is the
//                                      bridge read data broadcast to all,
//                                      qualified by rvalid_o
//   bus_req_o/we/be/addr/wdata       : request towards the bridge
//   bus_gnt_i/rvalid_i/rdata_i       : response from the bridge
//
// Handshake: a request transfers in the cycle where bus_req_o && bus_gnt_i;
// while bus_req_o is high and unanswered, bus_we/be/addr/wdata stay fixed.
// gnt_o mirrors bus_gnt_i combinationally to the selected requester. A
// response transfers in any cycle with bus_rvalid_i (no back-pressure) and is
// delivered to the FIFO head in that same cycle.
//
// Build option: define OBI_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no round-robin pointer). Default build is round-robin.
// -----------------------------------------------------------------------------
module obi_bridge_arbiter
    import obi_bridge_arb_pkg::*;
#(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned IdxW           = $clog2(NumReq)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumReq-1:0]            req_i,
    input  logic [NumReq-1:0]            we_i,
    input  logic [NumReq*ObiBeW-1:0]     be_i,
    input  logic [NumReq*ObiDataW-1:0]   addr_i,
    input  logic [NumReq*ObiDataW-1:0]   wdata_i,
    output logic [NumReq-1:0]            gnt_o,
    output logic [NumReq-1:0]            rvalid_o,
    output logic [NumReq*ObiDataW-1:0]   rdata_o,
    output logic                         bus_req_o,
    output logic                         bus_we_o,
    output logic [ObiBeW-1:0]            bus_be_o,
    output logic [ObiDataW-1:0]          bus_addr_o,
    output logic [ObiDataW-1:0]          bus_wdata_o,
    input  logic                         bus_gnt_i,
    input  logic                         bus_rvalid_i,
    input  logic [ObiDataW-1:0]          bus_rdata_i
);

    logic [0:0]      state_q, state_d;
    logic [IdxW-1:0] sel_q, sel_d;
    logic [IdxW-1:0] win_idx, cur_idx, head_idx;
    logic            win_found, bus_valid, grant;
    logic            fifo_full, fifo_empty, pop;
    logic            err_q;
    obi_req_t        bus_sel;
    obi_rsp_t        bus_rsp;
    arb_dbg_t        dbg;
    logic            unused_dbg;

`ifndef OBI_ARB_FIXED_PRIO_EN
    logic [IdxW-1:0] rr_q;
`endif

    // (base + off) mod NumReq, with both operands already below NumReq.
    function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                                 input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NumReq) sum = sum - NumReq;
        return IdxW'(sum);
    endfunction

    assign bus_rsp = '{gnt: bus_gnt_i, rvalid: bus_rvalid_i, rdata: bus_rdata_i};

    // Winner selection
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
`ifdef OBI_ARB_FIXED_PRIO_EN
            if (!win_found && req_i[i]) begin
                win_idx   = IdxW'(i);
                win_found = 1'b1;
            end
`else
            // Scan starting at the rr pointer so the last winner goes last.
            if (!win_found && req_i[wrap_add(rr_q, i)]) begin
                win_idx   = wrap_add(rr_q, i);
                win_found = 1'b1;
            end
`endif
        end
    end

    // FSM
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cur_idx   = win_idx;
        bus_valid = 1'b0;
        grant     = 1'b0;
        case (state_q)
            IDLE: begin
                cur_idx   = win_idx;
                bus_valid = win_found && !fifo_full;
                if (bus_valid) begin
                    if (bus_rsp.gnt) begin
                        grant = 1'b1;
                    end else begin
                        sel_d   = win_idx;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                cur_idx   = sel_q;
                bus_valid = req_i[sel_q];
                // A requester withdrawing mid-address-phase is abandoned.
                if (!req_i[sel_q]) begin
                    state_d = IDLE;
                end else if (bus_rsp.gnt) begin
                    grant   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_sel.req   = bus_valid;
        bus_sel.we    = we_i[cur_idx];
        bus_sel.be    = be_i[{cur_idx, 2'b00} +: ObiBeW];
        bus_sel.addr  = addr_i[{cur_idx, 5'b00000} +: ObiDataW];
        bus_sel.wdata = wdata_i[{cur_idx, 5'b00000} +: ObiDataW];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
            err_q   <= 1'b0;
`ifndef OBI_ARB_FIXED_PRIO_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            // Response with nothing outstanding: dropped, remembered.
            if (bus_rsp.rvalid && fifo_empty) err_q <= 1'b1;
`ifndef OBI_ARB_FIXED_PRIO_EN
            if (grant) rr_q <= wrap_add(cur_idx, 1);
`endif
        end
    end

    assign pop = bus_rsp.rvalid && !fifo_empty;

    obi_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .data_i  (cur_idx),
        .pop_i   (pop),
        .data_o  (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Outputs are forced quiet while reset is held, even though they are
    // combinational from live inputs.
    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (rst_ni && grant) gnt_o[cur_idx]     = 1'b1;
        if (rst_ni && pop)   rvalid_o[head_idx] = 1'b1;
    end

    assign rdata_o     = rst_ni ? {NumReq{bus_rsp.rdata}} : '0;
    assign bus_req_o   = rst_ni & bus_sel.req;
    assign bus_we_o    = rst_ni & bus_sel.we;
    assign bus_be_o    = rst_ni ? bus_sel.be    : '0;
    assign bus_addr_o  = rst_ni ? bus_sel.addr  : '0;
    assign bus_wdata_o = rst_ni ? bus_sel.wdata : '0;

    assign dbg        = '{state: state_q, err: err_q};
    assign unused_dbg = ^dbg;

endmodule
